// File: rtl/mem_bus_responder_if.sv
// ---------------------------------------------------------------------------
// mem_bus_responder_if
// Request/response bus between the core's memory initiator (master) and the
// memory-side responder (slave).
//
// Parameters
//   ADDR_W        byte-address width
// Signals
//   req_valid     request present                      (master -> slave)
//   req_ready     responder can accept a request       (slave  -> master)
//   req_write     1 = store, 0 = load                  (master -> slave)
//   req_size      0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned  load: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address of the lowest byte
//   req_wdata     store data, low 8/16/32 bits used
//   resp_valid    response present                     (slave  -> master)
//   resp_ready    initiator consumes the response      (master -> slave)
//   resp_rdata    extended load data, 0 for stores and errors
//   resp_err      request rejected, no RAM access made
// ---------------------------------------------------------------------------
interface mem_bus_responder_if #(
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
// Memory-side responder for the core's load/store requests. Accepts one
// byte/half/word request at a time, serialises it into little-endian byte
// accesses on an 8-bit synchronous RAM port, and returns load data zero- or
// sign-extended to 32 bits together with an error flag.
//
// Parameters
//   ADDR_W        byte-address width; addresses wrap mod 2**ADDR_W
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   bus           mem_bus_responder_if.slave request/response bus
//   ram_addr_o    byte address to RAM
//   ram_we_o      RAM byte write strobe
//   ram_wdata_o   RAM write byte
//   ram_rdata_i   RAM read byte, valid one cycle after ram_addr_o (we = 0)
//
// Configuration
//   MEM_RESP_MISALIGN_TRAP_EN  when defined, misaligned half/word requests are
//                              rejected with resp_err and make no RAM access.
//                              When undefined they proceed byte by byte.
// ---------------------------------------------------------------------------
module mem_bus_responder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_responder_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;       // byte index within the transfer
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;     // assembled load bytes, LSB first
  logic              err_q, err_d;

  logic [2:0]        num_bytes;
  logic [1:0]        cap_sel;
  logic [2:0]        ram_ptr;
  logic              misalign;

  assign num_bytes = (size_q == 2'd0) ? 3'd1 :
                     (size_q == 2'd1) ? 3'd2 : 3'd4;

  // Read capture lags the address by one cycle, so cycle k stores byte k-1.
  assign cap_sel = 2'(idx_q - 3'd1);

`ifdef MEM_RESP_MISALIGN_TRAP_EN
  assign misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          data_d  = '0;
          idx_d   = '0;
          if ((bus.req_size == 2'd3) || misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = bus.req_write ? WRITE : READ;
          end
        end
      end

      WRITE: begin
        if (idx_q == num_bytes - 3'd1) begin
          state_d = RESP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      READ: begin
        if (idx_q != 3'd0) begin
          data_d[{cap_sel, 3'b000} +: 8] = ram_rdata_i;
        end
        if (idx_q == num_bytes) begin
          state_d = RESP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, all decoded from the registered state so reset clears them
  // (including ram_we_o) without waiting for a clock edge.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = '0;
    ram_we_o       = (state_q == WRITE);
    ram_addr_o     = '0;
    ram_wdata_o    = '0;
    ram_ptr        = idx_q;

    // The last read cycle only captures, so the address stays on byte n-1.
    if ((state_q == READ) && (idx_q == num_bytes)) begin
      ram_ptr = idx_q - 3'd1;
    end

    if ((state_q == WRITE) || (state_q == READ)) begin
      ram_addr_o = addr_q + ADDR_W'(ram_ptr);
    end

    if (state_q == WRITE) begin
      ram_wdata_o = wdata_q[{idx_q[1:0], 3'b000} +: 8];
    end

    // data_q is zero for stores and rejected requests, so the extension
    // below yields 0 for them as well.
    if (state_q == RESP) begin
      unique case (size_q)
        2'd0:    bus.resp_rdata = uns_q ? {24'h0, data_q[7:0]}
                                        : {{24{data_q[7]}}, data_q[7:0]};
        2'd1:    bus.resp_rdata = uns_q ? {16'h0, data_q[15:0]}
                                        : {{16{data_q[15]}}, data_q[15:0]};
        default: bus.resp_rdata = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_responder
// Self-checking bench for mem_bus_responder: directed scenarios followed by
// randomized load/store traffic compared against a byte-array reference
// memory and the load/store rules expressed as plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_bus_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int tests = 0;
  int fails = 0;

  mem_bus_responder_if #(.ADDR_W(16)) bus ();

  mem_bus_responder #(.ADDR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM with one cycle of read latency.
  logic [7:0] mem [0:65535] = '{default: 8'h00};
  logic [7:0] rd_q;
  assign ram_rdata = rd_q;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_q <= mem[ram_addr];
  end

  // Reference memory contents as the bench believes them to be.
  logic [7:0] ref_mem [0:65535];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit exp_err(input logic [1:0] sz, input logic [15:0] a);
    bit mis;
    mis = 1'b0;
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    mis = ((sz == 2'd1) && (a % 2 != 0)) || ((sz == 2'd2) && (a % 4 != 0));
`endif
    return (sz == 2'd3) || mis;
  endfunction

  function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [1:0] sz, input bit uns);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[16'(a + k)]) << (8 * k));
    if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void ref_store(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int k = 0; k < nbytes(sz); k++) ref_mem[16'(a + k)] = 8'((wd >> (8 * k)) & 32'hFF);
  endfunction

  // One complete transaction. lat counts clock edges from the accept edge
  // (inclusive) until resp_valid is seen; wes counts cycles with ram_we high.
  task automatic run_txn(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [15:0] a, input logic [31:0] wd,
                         input int hold, input bit poke,
                         output logic [31:0] rd, output logic err,
                         output int lat, output int wes);
    logic [31:0] rd0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = 16'($urandom);
    bus.req_wdata    = $urandom;
    lat = 1;
    wes = 0;
    rd  = '0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) break;
      if (ram_we) wes++;
      lat++;
      if (lat > 40) begin
        check("resp_valid_timeout", 32'(bus.resp_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
    rd0 = rd;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 16'h0400;
        bus.req_wdata = 32'h0000_005A;
      end
      @(negedge clk);
      check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_resp_rdata", bus.resp_rdata, rd0);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("post_resp_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_resp_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wes;
    int          we_seen;
    bit          wr;
    bit          uns;
    logic [1:0]  sz;
    logic [15:0] a;
    logic [31:0] wd;
    bit          e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_we;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    rst_n            = 1'b0;

    // Reset state
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load at 0x0080
    run_txn(1'b1, 2'd2, 1'b0, 16'h0080, 32'h1122_3344, 0, 1'b0, rd, err, lat, wes);
    ref_store(16'h0080, 2'd2, 32'h1122_3344);
    check("st_w_err", 32'(err), 32'd0);
    check("st_w_rdata", rd, 32'd0);
    check("st_w_lat", 32'(lat), 32'd5);
    check("st_w_we_cycles", 32'(wes), 32'd4);
    check("st_w_ram80", 32'(mem[16'h0080]), 32'h44);
    check("st_w_ram81", 32'(mem[16'h0081]), 32'h33);
    check("st_w_ram82", 32'(mem[16'h0082]), 32'h22);
    check("st_w_ram83", 32'(mem[16'h0083]), 32'h11);

    run_txn(1'b0, 2'd2, 1'b0, 16'h0080, 32'h0, 0, 1'b0, rd, err, lat, wes);
    check("ld_w_rdata", rd, 32'h1122_3344);
    check("ld_w_err", 32'(err), 32'd0);
    check("ld_w_lat", 32'(lat), 32'd6);
    check("ld_w_we_cycles", 32'(wes), 32'd0);

    // Byte / half extension
    run_txn(1'b1, 2'd0, 1'b0, 16'h0079, 32'h0000_0080, 0, 1'b0, rd, err, lat, wes);
    ref_store(16'h0079, 2'd0, 32'h80);
    check("st_b_lat", 32'(lat), 32'd2);
    run_txn(1'b1, 2'd0, 1'b0, 16'h0078, 32'h0000_0058, 0, 1'b0, rd, err, lat, wes);
    ref_store(16'h0078, 2'd0, 32'h58);
    run_txn(1'b0, 2'd0, 1'b0, 16'h0079, 32'h0, 0, 1'b0, rd, err, lat, wes);
    check("ld_b_signed", rd, 32'hFFFF_FF80);
    check("ld_b_lat", 32'(lat), 32'd3);
    run_txn(1'b0, 2'd0, 1'b1, 16'h0079, 32'h0, 0, 1'b0, rd, err, lat, wes);
    check("ld_b_unsigned", rd, 32'h0000_0080);
    run_txn(1'b0, 2'd1, 1'b0, 16'h0078, 32'h0, 0, 1'b0, rd, err, lat, wes);
    check("ld_h_signed", rd, 32'hFFFF_8058);
    check("ld_h_lat", 32'(lat), 32'd4);

    // Address wrap: word at 0xFFFF
    run_txn(1'b1, 2'd0, 1'b0, 16'hFFFF, 32'h01, 0, 1'b0, rd, err, lat, wes);
    run_txn(1'b1, 2'd0, 1'b0, 16'h0000, 32'h02, 0, 1'b0, rd, err, lat, wes);
    run_txn(1'b1, 2'd0, 1'b0, 16'h0001, 32'h03, 0, 1'b0, rd, err, lat, wes);
    run_txn(1'b1, 2'd0, 1'b0, 16'h0002, 32'h04, 0, 1'b0, rd, err, lat, wes);
    ref_store(16'hFFFF, 2'd0, 32'h01);
    ref_store(16'h0000, 2'd0, 32'h02);
    ref_store(16'h0001, 2'd0, 32'h03);
    ref_store(16'h0002, 2'd0, 32'h04);
    check("wrap_ram_ffff", 32'(mem[16'hFFFF]), 32'h01);
    run_txn(1'b0, 2'd2, 1'b1, 16'hFFFF, 32'h0, 0, 1'b0, rd, err, lat, wes);
`ifdef MEM_RESP_MISALIGN_TRAP_EN
    check("wrap_ld_err", 32'(err), 32'd1);
    check("wrap_ld_rdata", rd, 32'd0);
    check("wrap_ld_lat", 32'(lat), 32'd1);
    check("wrap_ld_we_cycles", 32'(wes), 32'd0);
    run_txn(1'b1, 2'd2, 1'b0, 16'hFFFF, 32'hDEAD_BEEF, 0, 1'b0, rd, err, lat, wes);
    check("wrap_st_err", 32'(err), 32'd1);
    check("wrap_st_we_cycles", 32'(wes), 32'd0);
    check("wrap_st_ram_ffff", 32'(mem[16'hFFFF]), 32'h01);
`else
    check("wrap_ld_err", 32'(err), 32'd0);
    check("wrap_ld_rdata", rd, 32'h0403_0201);
    check("wrap_ld_lat", 32'(lat), 32'd6);
`endif

    // Reserved size: immediate error, no RAM write
    run_txn(1'b1, 2'd3, 1'b0, 16'h0090, 32'hFFFF_FFFF, 0, 1'b0, rd, err, lat, wes);
    check("sz3_err", 32'(err), 32'd1);
    check("sz3_rdata", rd, 32'd0);
    check("sz3_lat", 32'(lat), 32'd1);
    check("sz3_we_cycles", 32'(wes), 32'd0);
    check("sz3_ram90", 32'(mem[16'h0090]), 32'h00);

    // Back-pressure: 5 cycles without resp_ready while a new request knocks
    run_txn(1'b0, 2'd2, 1'b0, 16'h0080, 32'h0, 5, 1'b1, rd, err, lat, wes);
    check("hold_ld_rdata", rd, 32'h1122_3344);
    we_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ram_we) we_seen++;
    end
    check("hold_no_accept_we", 32'(we_seen), 32'd0);
    check("hold_no_accept_ram", 32'(mem[16'h0400]), 32'h00);

    // Reset during byte 2 of a word store
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 16'h0200;
    bus.req_wdata = 32'hAABB_CCDD;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_rst_we_before", 32'(ram_we), 32'd1);
    check("mid_rst_addr_before", 32'(ram_addr), 32'h0202);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we_drop", 32'(ram_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    ref_mem[16'h0200] = 8'hDD;
    ref_mem[16'h0201] = 8'hCC;
    check("mid_rst_ram200", 32'(mem[16'h0200]), 32'hDD);
    check("mid_rst_ram201", 32'(mem[16'h0201]), 32'hCC);
    check("mid_rst_ram202", 32'(mem[16'h0202]), 32'h00);
    check("mid_rst_ram203", 32'(mem[16'h0203]), 32'h00);

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = $urandom_range(0, 1) ? 16'(16'h0300 + $urandom_range(0, 15))
                                 : 16'(16'hFFFC + $urandom_range(0, 7));
      wd  = $urandom;
      e_err = exp_err(sz, a);
      e_rd  = (e_err || wr) ? 32'd0 : ref_load(a, sz, uns);
      e_lat = e_err ? 1 : (wr ? nbytes(sz) + 1 : nbytes(sz) + 2);
      e_we  = (e_err || !wr) ? 0 : nbytes(sz);
      run_txn(wr, sz, uns, a, wd, $urandom_range(0, 2), 1'b0, rd, err, lat, wes);
      check("rnd_err", 32'(err), 32'(e_err));
      check("rnd_rdata", rd, e_rd);
      check("rnd_lat", 32'(lat), 32'(e_lat));
      check("rnd_we_cycles", 32'(wes), 32'(e_we));
      if (!e_err && wr) ref_store(a, sz, wd);
    end

    // RAM contents in the random windows match the reference memory
    for (int j = 0; j < 20; j++) begin
      check("sweep_ram_lo", 32'(mem[16'(16'h0300 + j)]), 32'(ref_mem[16'(16'h0300 + j)]));
    end
    for (int j = 0; j < 12; j++) begin
      check("sweep_ram_wrap", 32'(mem[16'(16'hFFFC + j)]), 32'(ref_mem[16'(16'hFFFC + j)]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
